// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE,
    ZERO
  } div_state_e;
endpackage

// File: rtl/div_abs_neg.sv
// Two's-complement conditional negate; with neg tied to the sign bit it yields |din| as unsigned.
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);
  assign dout = neg ? (~din + WIDTH'(1)) : din;
endmodule

// File: rtl/seq_divider.sv
// Restoring signed divider, one quotient bit per cycle; MIPS DIV result placement (lo=quotient, hi=remainder).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero
);
  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem, q, divisor;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic             sign_q, sign_r;
  logic [WIDTH:0]   shifted, trial;
  logic             b_zero;

  assign b_zero  = (b == '0);
  // rem stays below divisor <= 2^(WIDTH-1), so WIDTH+1 bits hold the shifted value and trial sign
  assign shifted = {rem, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.din(a),   .neg(a[WIDTH-1]), .dout(a_mag));
  div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.din(b),   .neg(b[WIDTH-1]), .dout(b_mag));
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.din(q),   .neg(sign_q),     .dout(q_fix));
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.din(rem), .neg(sign_r),     .dout(r_fix));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = b_zero ? ZERO : CALC;
      CALC:    if (count == CNT_W'(WIDTH-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      rem      <= '0;
      q        <= '0;
      divisor  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      ready    <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !b_zero) begin
            q       <= a_mag;
            divisor <= b_mag;
            rem     <= '0;
            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r  <= a[WIDTH-1];
            count   <= '0;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end
        DONE: begin
          lo    <= q_fix;
          hi    <= r_fix;
          ready <= 1'b1;
        end
        ZERO: begin
          ready    <= 1'b1;
          div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signed results, divide-by-zero, ignored start and mid-op reset.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        ready, div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int pulses;

  seq_divider dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .hi(hi), .lo(lo), .ready(ready), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    logic [31:0] old_lo, old_hi;
    old_lo = lo; old_hi = hi;
    start_op(av, bv);
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 16) begin
        check({tag, "_lo_hold"}, lo, old_lo);
        check({tag, "_hi_hold"}, hi, old_hi);
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'd33);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_dz"}, {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    reset = 1'b1;

    run_div("d7_2",   32'd7,          32'd2,          32'h00000003, 32'h00000001);
    run_div("dm7_2",  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("d7_m2",  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001);
    run_div("d100_7", 32'd100,        32'd7,          32'd14,       32'd2);

    start_op(32'd5, 32'd0);
    @(negedge clk);
    check("dz_ready", {31'd0, ready}, 32'd1);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_hi_keep", hi, 32'd2);
    check("dz_lo_keep", lo, 32'd14);
    @(negedge clk);
    check("dz_ready_pulse", {31'd0, ready}, 32'd0);
    check("dz_flag_pulse", {31'd0, div_zero}, 32'd0);

    run_div("ovf",    32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000);
    run_div("d3_10",  32'd3,          32'd10,         32'd0,        32'd3);

    start_op(32'd1000, 32'd3);
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        a = 32'd9; b = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("ign_latency", 32'(cyc), 32'd33);
    check("ign_lo", lo, 32'd333);
    check("ign_hi", hi, 32'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("ign_no_extra", 32'(pulses), 32'd0);

    start_op(32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("abort_no_ready", 32'(pulses), 32'd0);
    run_div("d9_4", 32'd9, 32'd4, 32'd2, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
